// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one pipelined aes_128 core between two requesters,
// with tag-based response steering and a hold/drain controller.
module aes_core_arbiter #(
   parameter int AES_LAT = 21,
   parameter int CNT_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [127:0]       req0_state,
   input  logic [127:0]       req0_key,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [127:0]       req1_state,
   input  logic [127:0]       req1_key,
   output logic [127:0]       aes_state,
   output logic [127:0]       aes_key,
   input  logic [127:0]       aes_out,
   output logic               rsp0_valid,
   output logic               rsp1_valid,
   output logic [127:0]       rsp_data,
   input  logic               hold,
   output logic               drained,
   output logic [CNT_W-1:0]   inflight
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               prio_q, prio_d;
   logic [127:0]       st_q, st_d;
   logic [127:0]       key_q, key_d;
   logic [AES_LAT:0]   tv_q;
   logic [AES_LAT:0]   tid_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic gnt0, gnt1, issue_en, acc, rsp_v;

   // Grant is decided from valids and pointer; the FSM only gates it.
   assign gnt0     = req0_valid & (~req1_valid | ~prio_q);
   assign gnt1     = req1_valid & (~req0_valid | prio_q);
   assign issue_en = rst & (state_q == RUN);

   assign req0_ready = issue_en & gnt0;
   assign req1_ready = issue_en & gnt1;
   assign acc        = req0_ready | req1_ready;

   assign rsp_v      = rst & tv_q[AES_LAT];
   assign rsp0_valid = rsp_v & ~tid_q[AES_LAT];
   assign rsp1_valid = rsp_v & tid_q[AES_LAT];
   assign rsp_data   = aes_out;

   assign aes_state  = st_q;
   assign aes_key    = key_q;
   assign inflight   = cnt_q;
   assign drained    = rst & (state_q == HALT);

   always_comb begin
      st_d   = st_q;
      key_d  = key_q;
      prio_d = prio_q;
      cnt_d  = cnt_q;
      if (acc) begin
         st_d   = req1_ready ? req1_state : req0_state;
         key_d  = req1_ready ? req1_key   : req0_key;
         prio_d = ~req1_ready;
      end
      if (acc && !rsp_v) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!acc && rsp_v) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Using the next count lets drained rise right after the last response.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (hold) state_d = DRAIN;
         end
         DRAIN: begin
            if (!hold)              state_d = RUN;
            else if (cnt_d == '0)   state_d = HALT;
         end
         HALT: begin
            if (!hold) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         prio_q  <= 1'b0;
         st_q    <= '0;
         key_q   <= '0;
         tv_q    <= '0;
         tid_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         st_q    <= st_d;
         key_q   <= key_d;
         tv_q    <= {tv_q[AES_LAT-1:0], acc};
         tid_q   <= {tid_q[AES_LAT-1:0], req1_ready};
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter with a stub AES core of fixed latency.
// The stub knows the FIPS-197 vector; other blocks map to a simple xor mix.
module tb_aes_core_arbiter;

   localparam int LAT = 21;
   localparam int CW  = 5;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic          clk;
   logic          rst;
   logic          req0_valid, req0_ready;
   logic [127:0]  req0_state, req0_key;
   logic          req1_valid, req1_ready;
   logic [127:0]  req1_state, req1_key;
   logic [127:0]  aes_state, aes_key, aes_out;
   logic          rsp0_valid, rsp1_valid;
   logic [127:0]  rsp_data;
   logic          hold, drained;
   logic [CW-1:0] inflight;

   aes_core_arbiter #(.AES_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_state(req0_state), .req0_key(req0_key),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_state(req1_state), .req1_key(req1_key),
      .aes_state(aes_state), .aes_key(aes_key), .aes_out(aes_out),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_data(rsp_data), .hold(hold), .drained(drained),
      .inflight(inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int rsp_cnt = 0;
   int last_rsp_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] core_f(input logic [127:0] s,
                                           input logic [127:0] k);
      if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
      return s ^ {k[63:0], k[127:64]};
   endfunction

   logic [127:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= core_f(aes_state, aes_key);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign aes_out = pipe[LAT-1];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      int           cyc;
      logic         id;
      logic [127:0] data;
   } exp_t;

   exp_t         sb[$];
   logic         gq[$];
   logic         pend = 1'b0;
   logic [127:0] pend_st, pend_key;

   // Issue side: record every accept and its expected response.
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("aes_state", aes_state, pend_st);
            chk("aes_key", aes_key, pend_key);
         end
         pend = 1'b0;
         if (req0_valid && req0_ready) begin
            sb.push_back('{cyc + LAT + 1, 1'b0, core_f(req0_state, req0_key)});
            gq.push_back(1'b0);
            pend = 1'b1; pend_st = req0_state; pend_key = req0_key;
         end
         if (req1_valid && req1_ready) begin
            sb.push_back('{cyc + LAT + 1, 1'b1, core_f(req1_state, req1_key)});
            gq.push_back(1'b1);
            pend = 1'b1; pend_st = req1_state; pend_key = req1_key;
         end
      end
   end

   // Response side.
   always @(negedge clk) begin
      if (rsp0_valid || rsp1_valid) begin
         exp_t e;
         rsp_cnt++;
         last_rsp_cyc = cyc;
         chk("rsp_onehot", 128'(rsp0_valid & rsp1_valid), 128'(0));
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_rsp: got rsp0=%0b rsp1=%0b at cycle %0d expected none",
                     rsp0_valid, rsp1_valid, cyc);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", 128'(rsp1_valid), 128'(e.id));
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_cycle", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input int budget);
      for (int n = 0; n < budget && sb.size() != 0; n++) tick();
      chk("drain_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   int  drained_cyc;
   int  rsp_base;
   logic bad_ready;

   initial begin
      rst = 1'b0; hold = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_state = FIPS_PT; req0_key = FIPS_KEY;
      req1_state = '0; req1_key = '0;
      tick();
      chk("rst_ready0", 128'(req0_ready), 128'(0));
      chk("rst_rsp0", 128'(rsp0_valid), 128'(0));
      chk("rst_rsp1", 128'(rsp1_valid), 128'(0));
      chk("rst_drained", 128'(drained), 128'(0));
      chk("rst_inflight", 128'(inflight), 128'(0));
      chk("rst_aes_state", aes_state, 128'(0));
      chk("rst_aes_key", aes_key, 128'(0));
      rst = 1'b1;

      // FIPS-197 vector through requester 0
      #1;
      chk("t1_ready0", 128'(req0_ready), 128'(1));
      chk("t1_ready1", 128'(req1_ready), 128'(0));
      tick();
      req0_valid = 1'b0;
      chk("t1_inflight1", 128'(inflight), 128'(1));
      wait_empty(40);
      chk("t1_inflight0", 128'(inflight), 128'(0));

      // Both saturated from reset
      do_reset();
      gq.delete();
      for (int i = 0; i < 10; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_state = 128'h1000 + 128'(i); req0_key = 128'hA0;
         req1_state = 128'h2000 + 128'(i); req1_key = 128'hB1;
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("t2_inflight", 128'(inflight), 128'(10));
      chk("t2_grants", 128'(gq.size()), 128'(10));
      for (int i = 0; i < 10 && i < gq.size(); i++)
         chk("t2_grant_order", 128'(gq[i]), 128'(i % 2));
      wait_empty(40);

      // Steady streaming on requester 1
      for (int k = 1; k <= 30; k++) begin
         req1_valid = 1'b1;
         req1_state = 128'h3000 + 128'(k); req1_key = 128'hC3 + 128'(k);
         tick();
         if (k >= 22) chk("t3_inflight", 128'(inflight), 128'(22));
      end
      req1_valid = 1'b0;
      wait_empty(40);

      // Hold after 5 accepts
      rsp_base = rsp_cnt;
      for (int k = 0; k < 5; k++) begin
         req0_valid = 1'b1;
         req0_state = 128'h4000 + 128'(k); req0_key = 128'hD4;
         tick();
      end
      req0_valid = 1'b0;
      hold = 1'b1;
      tick();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req1_state = 128'h5000; req1_key = 128'hE5;
      drained_cyc = -1;
      bad_ready = 1'b0;
      #1;
      for (int n = 0; n < 40; n++) begin
         if (req0_ready || req1_ready) bad_ready = 1'b1;
         if (drained) begin
            drained_cyc = cyc;
            break;
         end
         tick();
      end
      chk("t4_no_ready", 128'(bad_ready), 128'(0));
      chk("t4_rsp_count", 128'(rsp_cnt - rsp_base), 128'(5));
      chk("t4_drained_cycle", 128'(drained_cyc), 128'(last_rsp_cyc + 1));
      hold = 1'b0;
      #1;
      chk("t4_ready_same_cycle", 128'(req0_ready | req1_ready), 128'(0));
      tick();
      chk("t4_ready1_after", 128'(req1_ready), 128'(1));
      chk("t4_ready0_after", 128'(req0_ready), 128'(0));
      chk("t4_drained_low", 128'(drained), 128'(0));
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_empty(40);

      // Reset with blocks in flight
      rsp_base = rsp_cnt;
      for (int k = 0; k < 3; k++) begin
         req0_valid = 1'b1;
         req0_state = 128'h6000 + 128'(k); req0_key = 128'hF6;
         tick();
      end
      req0_valid = 1'b0;
      repeat (10) tick();
      do_reset();
      chk("t5_inflight", 128'(inflight), 128'(0));
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_state = 128'h7000; req1_state = 128'h7100;
      #1;
      chk("t5_ready0", 128'(req0_ready), 128'(1));
      chk("t5_ready1", 128'(req1_ready), 128'(0));
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_empty(40);
      repeat (30) tick();
      chk("t5_rsp_count", 128'(rsp_cnt - rsp_base), 128'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
